// File: rtl/hilo_unit_if.sv
// Bundle of the pipeline-facing and multiplier-facing signals of the HI/LO unit.
// The slave modport is the unit itself; master is the surrounding pipeline and multiplier.
interface hilo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [1:0]  mul_req;
  logic        mul_busy;
  logic [63:0] mul_product;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  modport slave (
    input  op_valid, op, rs_val, rt_val, mul_busy, mul_product,
    output mul_a, mul_b, mul_req, stall, rd_data, rd_valid, hi, lo, err
  );

  modport master (
    output op_valid, op, rs_val, rt_val, mul_busy, mul_product,
    input  mul_a, mul_b, mul_req, stall, rd_data, rd_valid, hi, lo, err
  );
endinterface

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: launches the external iterative multiplier with operand
// magnitudes, sign-corrects the product on completion and serves MFHI/MFLO/MTHI/MTLO.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  hilo_unit_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  // Two's complement magnitude; 0x80000000 maps onto itself, which is the correct unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = ~v + 64'd1;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;
  logic [1:0]  mul_req_q, mul_req_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        neg_q, neg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [63:0] prod_q, prod_d;

  logic [TW-1:0] timer_inc_s;
  logic          timeout_s;
  logic [63:0]   result_s;

  assign timer_inc_s = timer_q + TW'(1);
  assign timeout_s   = (timer_inc_s >= TW'(TIMEOUT));
  assign result_s    = neg_q ? neg64(prod_q) : prod_q;

  // Next-state and datapath decisions for the multiply sequencer and HI/LO moves.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    mul_req_d  = mul_req_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    neg_d      = neg_q;
    timer_d    = timer_q;
    prod_d     = prod_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.op_valid) begin
          case (bus.op)
            OP_MULTU: begin
              mul_a_d   = bus.rs_val;
              mul_b_d   = bus.rt_val;
              neg_d     = 1'b0;
              mul_req_d = 2'b01;
              state_d   = S_ISSUE;
            end
            OP_MULT: begin
              mul_a_d   = mag32(bus.rs_val);
              mul_b_d   = mag32(bus.rt_val);
              neg_d     = bus.rs_val[31] ^ bus.rt_val[31];
              mul_req_d = 2'b01;
              state_d   = S_ISSUE;
            end
            OP_MFHI: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        timer_d = timer_inc_s;
        if (timeout_s) begin
          err_d     = 1'b1;
          mul_req_d = 2'b00;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else if (bus.mul_busy) begin
          mul_req_d = 2'b00;
          state_d   = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end

      // A product that lands on the last allowed cycle still wins over the abort.
      S_WAIT: begin
        timer_d = timer_inc_s;
        if (!bus.mul_busy) begin
          prod_d  = bus.mul_product;
          timer_d = '0;
          state_d = S_CAPTURE;
        end else if (timeout_s) begin
          err_d     = 1'b1;
          mul_req_d = 2'b00;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_CAPTURE: begin
        hi_d    = result_s[63:32];
        lo_d    = result_s[31:0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers; reset overrides everything including an in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      mul_req_q  <= 2'b00;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      neg_q      <= 1'b0;
      timer_q    <= '0;
      prod_q     <= 64'd0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      mul_req_q  <= mul_req_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      neg_q      <= neg_d;
      timer_q    <= timer_d;
      prod_q     <= prod_d;
    end
  end

  // NONE and the reserved encoding never touch HI/LO, so they never hold the pipeline.
  assign bus.stall = bus.op_valid && (bus.op != OP_NONE) && (bus.op != OP_RSVD) &&
                     (state_q != S_IDLE);

  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;
  assign bus.mul_req  = mul_req_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboarded bench for hilo_unit: directed ops with hand-computed results and a
// behavioural multiplier that can be made to hang or to return a chosen product.
module tb_hilo_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_unit_if bus ();
  hilo_unit #(.TIMEOUT(40)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [2:0] MULTU = 3'd1, MULT = 3'd2, MFHI = 3'd3, MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  bit hang = 1'b0;
  bit ovr = 1'b0;
  logic [63:0] ovr_prod = 64'd0;
  logic [31:0] seen_a, seen_b;
  int st;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got rd_valid data 0x%08h expected no read", bus.rd_data);
      end else begin
        chk32("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  // Multiplier model: latches operands when mul_req is raised, busy for a few cycles.
  initial begin
    bus.mul_busy    = 1'b0;
    bus.mul_product = 64'd0;
    forever begin
      @(posedge clk); #2;
      if (bus.mul_req != 2'b00 && !bus.mul_busy) begin
        seen_a = bus.mul_a;
        seen_b = bus.mul_b;
        bus.mul_busy = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        while (hang) begin @(posedge clk); #2; end
        bus.mul_product = ovr ? ovr_prod : ({32'd0, seen_a} * {32'd0, seen_b});
        bus.mul_busy = 1'b0;
      end
    end
  end

  // Starts and ends at a negedge; returns how many cycles the op was stalled.
  task automatic do_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] exp_rd, output int stalls);
    bus.op_valid = 1'b1;
    bus.op = o;
    bus.rs_val = rs;
    bus.rt_val = rt;
    stalls = 0;
    #1;
    while (bus.stall && stalls < 200) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 200) begin
      checks++;
      failures++;
      $display("FAIL stall_bound: got stall still high after %0d cycles expected release", stalls);
    end
    if (o == MFHI || o == MFLO) exp_q.push_back(exp_rd);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op = 3'd0;
  endtask

  task automatic do_mult(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ea, input logic [31:0] eb);
    int s;
    do_op(o, rs, rt, 32'd0, s);
    chk32("mul_issue_stall", s, 32'd0);
    chk32("mul_a", bus.mul_a, ea);
    chk32("mul_b", bus.mul_b, eb);
    chk32("mul_req", {30'd0, bus.mul_req}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0;
    bus.op = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk32("rst_hi", bus.hi, 32'd0);
    chk32("rst_lo", bus.lo, 32'd0);
    chk32("rst_rd_data", bus.rd_data, 32'd0);
    chk32("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk32("rst_err", {31'd0, bus.err}, 32'd0);
    chk32("rst_mul_req", {30'd0, bus.mul_req}, 32'd0);
    chk32("rst_mul_a", bus.mul_a, 32'd0);
    chk32("rst_mul_b", bus.mul_b, 32'd0);
    do_op(MFHI, 32'd0, 32'd0, 32'd0, st);
    chk32("mfhi_idle_stall", st, 32'd0);
    do_op(MFLO, 32'd0, 32'd0, 32'd0, st);
    chk32("mflo_idle_stall", st, 32'd0);

    // MULTU max * max with a pending MFLO
    do_mult(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(MFLO, 32'd0, 32'd0, 32'h00000001, st);
    chk32("multu_pending_stall", st, 32'd4);
    do_op(MFHI, 32'd0, 32'd0, 32'hFFFFFFFE, st);
    chk32("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk32("multu_lo", bus.lo, 32'h00000001);

    // MULT -3 * 5
    do_mult(MULT, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5);
    do_op(MFHI, 32'd0, 32'd0, 32'hFFFFFFFF, st);
    do_op(MFLO, 32'd0, 32'd0, 32'hFFFFFFF1, st);

    // MULT 0x80000000 * -1
    do_mult(MULT, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1);
    do_op(MFLO, 32'd0, 32'd0, 32'h80000000, st);
    do_op(MFHI, 32'd0, 32'd0, 32'h00000000, st);

    // Moves and reads, no stall
    do_op(MTHI, 32'h12345678, 32'd0, 32'd0, st);
    chk32("mthi_stall", st, 32'd0);
    do_op(MTLO, 32'h9ABCDEF0, 32'd0, 32'd0, st);
    do_op(MFHI, 32'd0, 32'd0, 32'h12345678, st);
    chk32("mfhi_stall", st, 32'd0);
    do_op(MFLO, 32'd0, 32'd0, 32'h9ABCDEF0, st);

    // MTHI during a multiply overwrites the product half after capture
    do_mult(MULT, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2);
    do_op(MTHI, 32'hCAFEF00D, 32'd0, 32'd0, st);
    chk32("mthi_pending_stall", st, 32'd4);
    do_op(MFHI, 32'd0, 32'd0, 32'hCAFEF00D, st);
    do_op(MFLO, 32'd0, 32'd0, 32'hFFFFFFF2, st);
    chk32("pre_timeout_err", {31'd0, bus.err}, 32'd0);

    // Hung multiplier: abort after 40 cycles in ISSUE+WAIT
    hang = 1'b1;
    do_mult(MULTU, 32'd2, 32'd3, 32'd2, 32'd3);
    do_op(MFHI, 32'd0, 32'd0, 32'hCAFEF00D, st);
    chk32("timeout_stall", st, 32'd40);
    chk32("timeout_err", {31'd0, bus.err}, 32'd1);
    chk32("timeout_mul_req", {30'd0, bus.mul_req}, 32'd0);
    hang = 1'b0;
    repeat (4) @(negedge clk);
    chk32("timeout_hi", bus.hi, 32'hCAFEF00D);
    chk32("timeout_lo", bus.lo, 32'hFFFFFFF2);
    chk32("err_sticky", {31'd0, bus.err}, 32'd1);

    // Reset in WAIT, product 1 arrives the following cycle and is ignored
    hang = 1'b1;
    do_mult(MULTU, 32'd4, 32'd5, 32'd4, 32'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ovr = 1'b1;
    ovr_prod = 64'd1;
    hang = 1'b0;
    chk32("rst_wait_mul_req", {30'd0, bus.mul_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk32("rst_wait_hi", bus.hi, 32'd0);
    chk32("rst_wait_lo", bus.lo, 32'd0);
    chk32("rst_wait_err", {31'd0, bus.err}, 32'd0);
    do_op(MFHI, 32'd0, 32'd0, 32'd0, st);
    chk32("rst_wait_stall", st, 32'd0);
    do_op(MFLO, 32'd0, 32'd0, 32'd0, st);
    ovr = 1'b0;
    repeat (2) @(negedge clk);

    chk32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
